// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle logic/ADD/SUB, iterative shift-add MUL and restoring DIV.
// Single-cycle ops finish the cycle after start; MUL/DIV hold busy for WIDTH cycles, and start is ignored while busy.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_a;      // multiplicand, or dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] r_b;      // multiplier, or divisor
  logic [WIDTH-1:0] r_acc;    // product accumulator, or partial remainder
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_dbz;
  logic             r_done;

  logic             w_accept;
  logic             w_launch;
  logic             w_single;
  logic             w_finish;
  logic [WIDTH-1:0] w_single_res;
  logic             w_single_dbz;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_trial;
  logic             w_div_neg;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_fin_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (ALU_Control == OP_MUL || (ALU_Control == OP_DIV && src_b != '0)) begin
            w_launch    = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(1)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_single = w_accept & ~w_launch;

  always_comb begin
    w_single_res = '0;
    w_single_dbz = 1'b0;
    case (ALU_Control)
      OP_ADD: w_single_res = src_a + src_b;
      OP_SUB: w_single_res = src_a - src_b;
      OP_DIV: begin
        // Only reaches here with a zero divisor
        w_single_res = '1;
        w_single_dbz = 1'b1;
      end
      OP_AND: w_single_res = src_a & src_b;
      OP_OR:  w_single_res = src_a | src_b;
      OP_XOR: w_single_res = src_a ^ src_b;
      OP_NOT: w_single_res = ~src_a;
      default: w_single_res = '0;
    endcase
  end

  // One iteration of each engine; the finishing cycle takes its result straight from here
  assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);
  assign w_rem_sh  = {r_acc, r_a[WIDTH-1]};
  assign w_trial   = {1'b0, w_rem_sh} - {2'b00, r_b};
  assign w_div_neg = w_trial[WIDTH+1];
  assign w_rem_nxt = w_div_neg ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {r_a[WIDTH-2:0], ~w_div_neg};
  assign w_fin_res = r_is_div ? w_quo_nxt : w_mul_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_a      <= src_a;
        r_b      <= src_b;
        r_acc    <= '0;
        r_cnt    <= CW'(WIDTH);
        r_is_div <= (ALU_Control == OP_DIV);
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CW'(1);
        if (r_is_div) begin
          r_acc <= w_rem_nxt;
          r_a   <= w_quo_nxt;
        end else begin
          r_acc <= w_mul_acc;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
        end
      end

      if (w_single) begin
        r_result <= w_single_res;
        r_zero   <= (w_single_res == '0);
        r_dbz    <= w_single_dbz;
        r_done   <= 1'b1;
      end else if (w_finish) begin
        r_result <= w_fin_res;
        r_zero   <= (w_fin_res == '0);
        r_dbz    <= 1'b0;
        r_done   <= 1'b1;
      end
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = r_done;
  assign result      = r_result;
  assign zero        = r_zero;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized and directed bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   ALU_Control;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALU_Control(ALU_Control),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .result(result), .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; return p[W-1:0]; end
      4'd3: return (b == 0) ? {W{1'b1}} : a / b;
      4'd4: return a & b;
      4'd5: return a | b;
      4'd6: return a ^ b;
      4'd7: return ~a;
      default: return '0;
    endcase
  endfunction

  // Issues one op (starting at the next falling edge) and checks latency, busy span, hold and outputs.
  // poke > 0 pulses an ADD start in that cycle of a multi-cycle op, which must be ignored.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    logic [W-1:0] exp_res;
    logic [W-1:0] held;
    int exp_lat;
    int lat;
    int busy_n;
    exp_res = model(op, a, b);
    exp_lat = (op == 4'd2 || (op == 4'd3 && b != 0)) ? W + 1 : 1;
    @(negedge clk);
    held = result;
    start = 1'b1; ALU_Control = op; src_a = a; src_b = b;
    lat = 0;
    busy_n = 0;
    for (int c = 1; c <= 3 * W; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ALU_Control = 4'($urandom); src_a = $urandom; src_b = $urandom;
      if (done) begin
        lat = c;
        break;
      end
      if (busy) busy_n++;
      check_eq("hold", result, held);
      if (c == poke) begin
        @(negedge clk);
        start = 1'b1; ALU_Control = 4'd0; src_a = 1; src_b = 1;
      end
    end
    check_eq("latency", lat, exp_lat);
    check_eq("busy_cycles", busy_n, exp_lat - 1);
    check_eq("busy_at_done", busy, 0);
    check_eq("result", result, exp_res);
    check_eq("zero", zero, exp_res == 0);
    check_eq("div_by_zero", div_by_zero, op == 4'd3 && b == 0);
  endtask

  initial begin
    logic [W-1:0] a, b, last;
    logic [3:0] op;
    int dones;
    rst_n = 1'b0; start = 1'b0; ALU_Control = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_zero", zero, 1);
    check_eq("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd0, 32'hFFFFFFFF, 32'h1, 0);
    run_op(4'd1, 32'd5, 32'd7, 0);
    check_eq("sub_val", result, 32'hFFFFFFFE);
    run_op(4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
    check_eq("and_val", result, 32'h00F000F0);
    run_op(4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
    check_eq("or_val", result, 32'hFFF0FFF0);
    run_op(4'd6, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
    check_eq("xor_val", result, 32'hFF00FF00);
    run_op(4'd7, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
    check_eq("not_val", result, 32'h0F0F0F0F);
    run_op(4'b1010, 32'h12345678, 32'h9ABCDEF0, 0);
    run_op(4'd2, 32'd7, 32'd6, 5);
    check_eq("mul_val", result, 42);
    last = result;
    @(posedge clk); #1;
    check_eq("done_single_pulse", done, 0);
    check_eq("idle_hold", result, last);
    run_op(4'd2, 32'h00010000, 32'h00010000, 0);
    run_op(4'd3, 32'd100, 32'd7, 0);
    check_eq("div_val", result, 14);
    run_op(4'd3, 32'hFFFFFFFF, 32'd1, 0);
    run_op(4'd3, 32'd9, 32'd0, 0);
    run_op(4'd0, 32'd2, 32'd3, 0);

    // Reset asserted in cycle 10 of a divide
    @(negedge clk);
    start = 1'b1; ALU_Control = 4'd3; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_result", result, 0);
    check_eq("abort_zero", zero, 1);
    check_eq("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_eq("abort_no_done", dones, 0);
    run_op(4'd2, 32'd3, 32'd3, 0);
    check_eq("mul_after_rst", result, 9);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'd3;
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = $urandom_range(1, 1000);
        2:       a = $urandom_range(0, 255);
        default: b = $urandom;
      endcase
      if (op == 4'd2 || op == 4'd3) begin
        if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
      end
      run_op(op, a, b, (op == 4'd2 || op == 4'd3) ? int'($urandom_range(0, W)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
